vx_hazard_scoreboard: RTL and testbench
=======================================

VX_HAZARD_SCOREBOARD -- requirements
Module: VX_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_WIS, default ISSUE_WIS (1 << ISSUE_WIS_W); warps tracked per issue slice.
REQ-002 SHALL have parameter NUM_REGS, default 2**`NR_BITS; tracked registers per warp (int + fp).
REQ-003 SHALL have parameter DATAW, default ibuffer DATAW; width of the pass-through instruction payload.
REQ-004 SHALL have port clk  in  1  sole clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid, in_ready  in/out  1  handshake from the ibuffer slice.
REQ-007 SHALL have port in_data  in  DATAW  payload; fields wis, wb, rd, rs1, rs2, rs3 are extracted via package accessors.
REQ-008 SHALL have ports out_valid, out_ready  out/in  1  handshake to the dispatch stage.
REQ-009 SHALL have port out_data  out  DATAW  payload, unmodified.
REQ-010 SHALL have ports wb_valid, wb_eop  in  1  writeback commit; wb_eop marks the last packet.
REQ-011 SHALL have ports wb_wis, wb_rd  in  ISSUE_WIS_W, NR_BITS  writeback target.

Function
REQ-012 SHALL keep bitmap inuse[NUM_WIS][NUM_REGS]; register index 0 is never set.
REQ-013 SHALL compute hazard = in_valid && (inuse[wis][rs1] | inuse[wis][rs2] | inuse[wis][rs3] | (wb && inuse[wis][rd])) from registered state only.
REQ-014 SHALL assert in_ready = !hazard && output stage can accept.
REQ-015 SHALL move an input fire (in_valid && in_ready) into a one-entry output register: 1-cycle latency, full throughput when out_ready is held high.
REQ-016 SHALL set inuse[wis][rd] on the input fire cycle when wb=1 and rd!=0; the bit is visible to the next cycle's hazard check.
REQ-017 SHALL clear inuse[wb_wis][wb_rd] on wb_valid && wb_eop; the release unblocks the input no earlier than the following cycle.
REQ-018 SHALL apply set over clear when both target the same bit in the same cycle.
REQ-019 SHALL ignore wb_valid without wb_eop, and a clear of an already-clear bit, without error.
REQ-020 SHALL hold out_valid/out_data stable while out_valid && !out_ready.
REQ-021 SHALL never reorder instructions; a stalled head blocks all later entries (in-order slice).

Reset
REQ-022 SHALL, while reset_n=0, clear all inuse bits, drive out_valid=0, and drive in_ready=0.
REQ-023 SHALL drop any instruction held in the output register when reset asserts mid-transfer.
REQ-024 SHALL NOT retain any writeback that arrives while reset_n=0.

Configuration
REQ-025 SHALL, when SCOREBOARD_PERF_EN is defined, expose output perf_stalls [PERF_CTR_BITS-1:0], reset to 0, incrementing by 1 each cycle in_valid && hazard, saturating at its maximum value.
REQ-026 SHALL, when SCOREBOARD_PERF_EN is undefined, have no perf_stalls port and no counter logic.

Structure
REQ-027 SHALL place sb_instr_t field accessors and constant NUM_SB_REGS in VX_gpu_pkg.
REQ-028 SHALL implement the output stage as sub-module VX_pipe_buffer (depth 1, registered outputs).

Verification
REQ-029 SHALL test RAW: issue wis=2 wb=1 rd=5, then rs1=5 on wis=2 -> second instruction stalls until the cycle after wb_valid&&wb_eop(wis=2, rd=5).
REQ-030 SHALL test warp isolation: inuse[1][7]=1, input wis=3 rs2=7 -> issues with no stall, 1-cycle latency.
REQ-031 SHALL test WAW: pending rd=9 on wis=0, new instruction wb=1 rd=9 -> stalls; wb_eop=0 writebacks -> remains stalled.
REQ-032 SHALL test same-cycle events: fire sets [0][4] while wb clears [0][4] -> bit is 1 afterward.
REQ-033 SHALL test backpressure: out_ready=0 for 3 cycles -> out_data is unchanged, in_ready=0, nothing is lost.
REQ-034 SHALL test reset: reset_n low with 4 bits set and out_valid=1 -> all bits 0, out_valid=0, perf_stalls=0 (when SCOREBOARD_PERF_EN is defined).

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// Shared GPU issue-path types: scoreboard instruction view of the ibuffer payload,
// register/warp geometry and payload field accessors.
package vx_gpu_pkg;

  localparam int ISSUE_WIS_W   = 2;
  localparam int ISSUE_WIS     = 1 << ISSUE_WIS_W;
  localparam int NR_BITS       = 6;
  localparam int NUM_SB_REGS   = 2 ** NR_BITS;
  localparam int PERF_CTR_BITS = 16;

  // Scoreboard-relevant fields occupy the low bits of the ibuffer payload.
  typedef struct packed {
    logic [ISSUE_WIS_W-1:0] wis;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [NR_BITS-1:0]     rs2;
    logic [NR_BITS-1:0]     rs3;
  } sb_instr_t;

  localparam int SB_INSTR_W = $bits(sb_instr_t);
  localparam int IBUF_TAG_W = 16;
  localparam int IBUF_DATAW = IBUF_TAG_W + SB_INSTR_W;

  function automatic logic [ISSUE_WIS_W-1:0] sb_get_wis(input logic [SB_INSTR_W-1:0] raw);
    sb_instr_t instr;
    instr = sb_instr_t'(raw);
    return instr.wis;
  endfunction

  function automatic logic sb_get_wb(input logic [SB_INSTR_W-1:0] raw);
    sb_instr_t instr;
    instr = sb_instr_t'(raw);
    return instr.wb;
  endfunction

  function automatic logic [NR_BITS-1:0] sb_get_rd(input logic [SB_INSTR_W-1:0] raw);
    sb_instr_t instr;
    instr = sb_instr_t'(raw);
    return instr.rd;
  endfunction

  function automatic logic [NR_BITS-1:0] sb_get_rs1(input logic [SB_INSTR_W-1:0] raw);
    sb_instr_t instr;
    instr = sb_instr_t'(raw);
    return instr.rs1;
  endfunction

  function automatic logic [NR_BITS-1:0] sb_get_rs2(input logic [SB_INSTR_W-1:0] raw);
    sb_instr_t instr;
    instr = sb_instr_t'(raw);
    return instr.rs2;
  endfunction

  function automatic logic [NR_BITS-1:0] sb_get_rs3(input logic [SB_INSTR_W-1:0] raw);
    sb_instr_t instr;
    instr = sb_instr_t'(raw);
    return instr.rs3;
  endfunction

endpackage

// File: rtl/vx_pipe_buffer.sv
// Single-entry pipeline register with valid/ready handshake and registered outputs;
// accepts a new entry in the same cycle the held one drains.
module vx_pipe_buffer #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  logic             valid_q;
  logic [DATAW-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/vx_hazard_scoreboard.sv
// In-order RAW/WAW hazard scoreboard for one issue slice, with a one-entry output stage.
// Optional stall counter output perf_stalls is built when SCOREBOARD_PERF_EN is defined.
module vx_hazard_scoreboard
  import vx_gpu_pkg::*;
#(
  parameter int NUM_WIS  = ISSUE_WIS,
  parameter int NUM_REGS = NUM_SB_REGS,
  parameter int DATAW    = IBUF_DATAW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAW-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAW-1:0]       out_data,
  input  logic                   wb_valid,
  input  logic                   wb_eop,
  input  logic [ISSUE_WIS_W-1:0] wb_wis,
  input  logic [NR_BITS-1:0]     wb_rd
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  logic [NUM_WIS-1:0][NUM_REGS-1:0] inuse;
  logic [NUM_REGS-1:0]              row;
  logic [ISSUE_WIS_W-1:0]           instr_wis;
  logic                             instr_wb;
  logic [NR_BITS-1:0]               instr_rd;
  logic [NR_BITS-1:0]               instr_rs1;
  logic [NR_BITS-1:0]               instr_rs2;
  logic [NR_BITS-1:0]               instr_rs3;
  logic                             hazard;
  logic                             buf_ready;
  logic                             in_fire;

  always_comb begin
    instr_wis = sb_get_wis(in_data[SB_INSTR_W-1:0]);
    instr_wb  = sb_get_wb(in_data[SB_INSTR_W-1:0]);
    instr_rd  = sb_get_rd(in_data[SB_INSTR_W-1:0]);
    instr_rs1 = sb_get_rs1(in_data[SB_INSTR_W-1:0]);
    instr_rs2 = sb_get_rs2(in_data[SB_INSTR_W-1:0]);
    instr_rs3 = sb_get_rs3(in_data[SB_INSTR_W-1:0]);
  end

  // Hazard reads only registered state, so a same-cycle release never bypasses.
  always_comb begin
    row    = inuse[instr_wis];
    hazard = in_valid && (row[instr_rs1] || row[instr_rs2] || row[instr_rs3]
                          || (instr_wb && row[instr_rd]));
  end

  assign in_ready = reset_n && !hazard && buf_ready;
  assign in_fire  = in_valid && in_ready;

  // The set is ordered after the clear so it wins when both hit the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inuse <= '0;
    end else begin
      if (wb_valid && wb_eop) begin
        inuse[wb_wis][wb_rd] <= 1'b0;
      end
      if (in_fire && instr_wb && (instr_rd != '0)) begin
        inuse[instr_wis][instr_rd] <= 1'b1;
      end
    end
  end

  vx_pipe_buffer #(
    .DATAW(DATAW)
  ) out_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_fire),
    .in_ready (buf_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stalls <= '0;
    end else if (hazard && (perf_stalls != '1)) begin
      perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vx_hazard_scoreboard.sv
// Directed bench for vx_hazard_scoreboard: issue order checked by a queue-based monitor,
// hazard timing checked through stall-cycle counts.
module tb_vx_hazard_scoreboard;
  import vx_gpu_pkg::*;

  localparam int DW = IBUF_DATAW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          wb_valid;
  logic          wb_eop;
  logic [1:0]    wb_wis;
  logic [5:0]    wb_rd;
`ifdef SCOREBOARD_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stalls;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  vx_hazard_scoreboard dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .wb_valid (wb_valid),
    .wb_eop   (wb_eop),
    .wb_wis   (wb_wis),
    .wb_rd    (wb_rd)
`ifdef SCOREBOARD_PERF_EN
    ,
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Payload layout: {tag, wis, wb, rd, rs1, rs2, rs3}
  function automatic logic [DW-1:0] mk(input logic [15:0] tag, input logic [1:0] wis,
                                       input logic wb, input logic [5:0] rd,
                                       input logic [5:0] rs1, input logic [5:0] rs2,
                                       input logic [5:0] rs3);
    return {tag, wis, wb, rd, rs1, rs2, rs3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [1:0] wis, input logic [5:0] rd, input logic eop);
    wb_valid = 1'b1;
    wb_eop   = eop;
    wb_wis   = wis;
    wb_rd    = rd;
    tick();
    wb_valid = 1'b0;
    wb_eop   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input int max_stall, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    @(negedge clk);
    while (!in_ready && stalls < max_stall) begin
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_out", out_data, '0);
      end else begin
        chk("mon_out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    logic [DW-1:0] x;
    logic [DW-1:0] d;

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(16'hdead, 2'd1, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0);
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_eop    = 1'b0;
    wb_wis    = '0;
    wb_rd     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // RAW on warp 2, register 5
    send(mk(16'h1, 2'd2, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0), 20, s);
    chk("raw_producer_stall", s, 0);
    fork
      send(mk(16'h2, 2'd2, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0), 20, s);
      begin repeat (3) tick(); wb(2'd2, 6'd5, 1'b1); end
    join
    chk("raw_stall_cycles", s, 4);

    // Warp isolation
    send(mk(16'h3, 2'd1, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0), 20, s);
    chk("iso_producer_stall", s, 0);
    d = mk(16'h4, 2'd3, 1'b0, 6'd0, 6'd0, 6'd7, 6'd0);
    send(d, 20, s);
    chk("iso_stall", s, 0);
    @(negedge clk);
    chk("iso_latency_valid", out_valid, 1);
    chk("iso_latency_data", out_data, d);
    #1;
    wb(2'd1, 6'd7, 1'b1);

    // WAW with non-final writeback packets
    send(mk(16'h5, 2'd0, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0), 20, s);
    chk("waw_producer_stall", s, 0);
    fork
      send(mk(16'h6, 2'd0, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0), 20, s);
      begin
        tick();
        wb(2'd0, 6'd9, 1'b0);
        wb(2'd0, 6'd9, 1'b0);
        wb(2'd0, 6'd9, 1'b0);
        wb(2'd0, 6'd9, 1'b1);
      end
    join
    chk("waw_stall_cycles", s, 5);
    wb(2'd0, 6'd9, 1'b1);

    // Same-cycle set and clear of [0][4]
    fork
      send(mk(16'h7, 2'd0, 1'b1, 6'd4, 6'd0, 6'd0, 6'd0), 20, s);
      wb(2'd0, 6'd4, 1'b1);
    join
    chk("same_cycle_issue_stall", s, 0);
    fork
      send(mk(16'h8, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd4), 20, s);
      begin repeat (2) tick(); wb(2'd0, 6'd4, 1'b1); end
    join
    chk("same_cycle_set_wins", s, 3);

    // Register 0 is never tracked; clearing a clear bit is harmless
    send(mk(16'h9, 2'd1, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0), 20, s);
    send(mk(16'ha, 2'd1, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0), 20, s);
    chk("reg0_never_set", s, 0);
    wb(2'd1, 6'd20, 1'b1);
    send(mk(16'hb, 2'd1, 1'b0, 6'd0, 6'd20, 6'd0, 6'd0), 20, s);
    chk("clear_of_clear_bit", s, 0);

    // Backpressure
    tick();
    out_ready = 1'b0;
    x = mk(16'hc, 2'd2, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
    send(x, 20, s);
    chk("bp_first_stall", s, 0);
    fork
      send(mk(16'hd, 2'd2, 1'b0, 6'd0, 6'd1, 6'd2, 6'd3), 20, s);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_out_data", out_data, x);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_stall_cycles", s, 3);

    // Reset with four bits set and an instruction held
    send(mk(16'he, 2'd0, 1'b1, 6'd10, 6'd0, 6'd0, 6'd0), 20, s);
    send(mk(16'hf, 2'd1, 1'b1, 6'd11, 6'd0, 6'd0, 6'd0), 20, s);
    send(mk(16'h10, 2'd2, 1'b1, 6'd12, 6'd0, 6'd0, 6'd0), 20, s);
    tick();
    out_ready = 1'b0;
    send(mk(16'h11, 2'd3, 1'b1, 6'd13, 6'd0, 6'd0, 6'd0), 20, s);
    chk("rst_pre_issue_stall", s, 0);
    @(negedge clk);
    chk("rst_pre_out_valid", out_valid, 1);
`ifdef SCOREBOARD_PERF_EN
    chk("perf_stall_count", perf_stalls, 12);
`endif
    #2;
    reset_n  = 1'b0;
    wb_valid = 1'b1;
    wb_eop   = 1'b1;
    wb_wis   = 2'd0;
    wb_rd    = 6'd10;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
`ifdef SCOREBOARD_PERF_EN
    chk("rst_perf_stalls", perf_stalls, 0);
`endif
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    wb_valid  = 1'b0;
    wb_eop    = 1'b0;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    send(mk(16'h12, 2'd0, 1'b0, 6'd0, 6'd10, 6'd0, 6'd0), 20, s);
    chk("rst_cleared_w0r10", s, 0);
    send(mk(16'h13, 2'd1, 1'b0, 6'd0, 6'd11, 6'd0, 6'd0), 20, s);
    chk("rst_cleared_w1r11", s, 0);
    send(mk(16'h14, 2'd2, 1'b0, 6'd0, 6'd0, 6'd12, 6'd0), 20, s);
    chk("rst_cleared_w2r12", s, 0);
    send(mk(16'h15, 2'd3, 1'b1, 6'd13, 6'd0, 6'd0, 6'd0), 20, s);
    chk("rst_cleared_w3r13", s, 0);

    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
